// File: rtl/jam_cost_pkg.sv
// Shared constants and state encoding for the JAM cost-matrix responder.
package jam_cost_pkg;

    localparam int unsigned WORKERS = 8;
    localparam int unsigned COST_W  = 7;
    localparam int unsigned TOTAL_W = 13;
    localparam int unsigned IDX_W   = 6;

    localparam logic [IDX_W-1:0] LAST_IDX = '1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_HOLD  = 3'd2,
        ST_SERVE = 3'd3,
        ST_ERR   = 3'd4
    } state_e;

endpackage

// File: rtl/jam_cost_table_loader.sv
// Load sequencer: FSM, beat index, framing check and running cost total.
module jam_cost_loader
    import jam_cost_pkg::*;
(
    input  logic               CLK,
    input  logic               RST,
    input  logic               in_valid,
    input  logic               in_last,
    input  logic [COST_W-1:0]  in_data,
    output logic               in_ready,
    output logic               wr_en_o,
    output logic [IDX_W-1:0]   wr_idx_o,
    output logic               serve_o,
    output logic               JAM_RST,
    output logic               Table_Ready,
    output logic               Load_Err,
    output logic [TOTAL_W-1:0] Total
);

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [TOTAL_W-1:0] total_q, total_d;
    logic               accept;

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        total_d  = total_q;
        in_ready = 1'b0;
        accept   = 1'b0;
        case (state_q)
            ST_IDLE, ST_LOAD: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept  = 1'b1;
                    idx_d   = idx_q + 1'b1;
                    total_d = total_q + TOTAL_W'(in_data);
                    // The offending beat is still written; only the state reacts.
                    if (idx_q == LAST_IDX)
                        state_d = in_last ? ST_HOLD : ST_ERR;
                    else
                        state_d = in_last ? ST_ERR : ST_LOAD;
                end
            end
            ST_HOLD: state_d = ST_SERVE;
            default: state_d = state_q;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            total_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            total_q <= total_d;
        end
    end

    assign wr_en_o     = accept & ~RST;
    assign wr_idx_o    = idx_q;
    assign serve_o     = (state_q == ST_SERVE);
    assign JAM_RST     = (state_q != ST_SERVE);
    assign Table_Ready = (state_q == ST_SERVE);
    assign Load_Err    = (state_q == ST_ERR);
    assign Total       = total_q;

endmodule

// File: rtl/jam_cost_table.sv
// 8x8 cost table for the JAM engine: streamed load, zero-latency masked lookup.
module jam_cost_table
    import jam_cost_pkg::*;
(
    input  logic               CLK,
    input  logic               RST,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [COST_W-1:0]  in_data,
    input  logic               in_last,
    input  logic [2:0]         W,
    input  logic [2:0]         J,
    output logic [COST_W-1:0]  Cost,
    output logic               JAM_RST,
    output logic               Table_Ready,
    output logic               Load_Err,
    output logic [TOTAL_W-1:0] Total
);

    logic               wr_en;
    logic [IDX_W-1:0]   wr_idx;
    logic               serve;
    logic [COST_W-1:0]  tbl_q [WORKERS*WORKERS];

    jam_cost_loader u_loader (
        .CLK         (CLK),
        .RST         (RST),
        .in_valid    (in_valid),
        .in_last     (in_last),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .wr_en_o     (wr_en),
        .wr_idx_o    (wr_idx),
        .serve_o     (serve),
        .JAM_RST     (JAM_RST),
        .Table_Ready (Table_Ready),
        .Load_Err    (Load_Err),
        .Total       (Total)
    );

    // Contents are deliberately unreset; the SERVE mask below hides stale data.
    always_ff @(posedge CLK) begin
        if (wr_en)
            tbl_q[wr_idx] <= in_data;
    end

    assign Cost = serve ? tbl_q[{W, J}] : '0;

endmodule

// File: tb/tb_jam_cost_table.sv
// Directed bench for jam_cost_table with a beat-count reference model.
module tb_jam_cost_table;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [6:0]  in_data = '0;
    logic        in_last = 1'b0;
    logic [2:0]  W = '0;
    logic [2:0]  J = '0;
    logic [6:0]  Cost;
    logic        JAM_RST;
    logic        Table_Ready;
    logic        Load_Err;
    logic [12:0] Total;

    jam_cost_table dut (
        .CLK         (CLK),
        .RST         (RST),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_last     (in_last),
        .W           (W),
        .J           (J),
        .Cost        (Cost),
        .JAM_RST     (JAM_RST),
        .Table_Ready (Table_Ready),
        .Load_Err    (Load_Err),
        .Total       (Total)
    );

    always #5 CLK = ~CLK;

    int n_total = 0;
    int n_bad   = 0;
    bit chk_en  = 1'b0;

    // Reference: count accepted beats; loaded/err flags; serving one cycle after loaded.
    int m_tab [64];
    int m_cnt = 0;
    int m_total = 0;
    bit m_loaded = 1'b0;
    bit m_err = 1'b0;
    bit m_serving = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        if (RST) begin
            m_cnt = 0; m_total = 0; m_loaded = 0; m_err = 0; m_serving = 0;
        end else if (m_loaded) begin
            m_serving = 1'b1;
        end else if (!m_err && in_valid) begin
            m_tab[m_cnt] = int'(in_data);
            m_total += int'(in_data);
            if (m_cnt == 63) begin
                if (in_last) m_loaded = 1'b1; else m_err = 1'b1;
            end else if (in_last) begin
                m_err = 1'b1;
            end
            m_cnt++;
        end
    endtask

    // One cycle: apply inputs (random lookup address), advance model at the edge.
    task automatic drive(input bit v, input int d, input bit l, input bit r);
        RST = r; in_valid = v; in_data = 7'(d); in_last = l;
        W = 3'($urandom_range(0, 7)); J = 3'($urandom_range(0, 7));
        @(posedge CLK);
        model_step();
        #1;
    endtask

    always @(negedge CLK) begin
        if (chk_en) begin
            chk("in_ready", int'(in_ready), int'(!m_err && !m_loaded));
            chk("JAM_RST", int'(JAM_RST), int'(!m_serving));
            chk("Table_Ready", int'(Table_Ready), int'(m_serving));
            chk("Load_Err", int'(Load_Err), int'(m_err));
            chk("Total", int'(Total), m_total);
            chk("Cost", int'(Cost), m_serving ? m_tab[{W, J}] : 0);
        end
    end

    task automatic do_reset();
        drive(0, 0, 0, 1);
        drive(0, 0, 0, 1);
        RST = 1'b0;
    endtask

    task automatic peek(input int w, input int j, input int exp, input string name);
        W = 3'(w); J = 3'(j);
        #1;
        chk(name, int'(Cost), exp);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();
        chk_en = 1'b1;
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_JAM_RST", int'(JAM_RST), 1);
        chk("rst_Table_Ready", int'(Table_Ready), 0);
        chk("rst_Load_Err", int'(Load_Err), 0);
        chk("rst_Total", int'(Total), 0);
        chk("rst_Cost", int'(Cost), 0);

        // Clean load, cost = k.
        for (int k = 0; k < 64; k++) drive(1, k, k == 63, 0);
        chk("hold_JAM_RST", int'(JAM_RST), 1);
        chk("hold_in_ready", int'(in_ready), 0);
        drive(0, 0, 0, 0);
        chk("serve_JAM_RST", int'(JAM_RST), 0);
        chk("serve_Table_Ready", int'(Table_Ready), 1);
        chk("load1_Total", int'(Total), 2016);
        peek(3, 5, 29, "cost_3_5");
        peek(7, 7, 63, "cost_7_7");
        // Beats in SERVE are ignored.
        for (int k = 0; k < 4; k++) drive(1, 127, 1, 0);
        peek(0, 0, 0, "cost_0_0");
        chk("serve_Total_held", int'(Total), 2016);

        // Same load with gaps every other cycle.
        do_reset();
        for (int k = 0; k < 64; k++) begin
            drive(1, k, k == 63, 0);
            if (k != 63) drive(0, $urandom_range(0, 127), 1, 0);
        end
        drive(0, 0, 0, 0);
        chk("gap_Total", int'(Total), 2016);
        peek(3, 5, 29, "gap_cost_3_5");
        peek(7, 7, 63, "gap_cost_7_7");

        // Early in_last on beat 10.
        do_reset();
        for (int k = 0; k <= 10; k++) drive(1, k + 1, k == 10, 0);
        chk("early_Load_Err", int'(Load_Err), 1);
        chk("early_in_ready", int'(in_ready), 0);
        chk("early_JAM_RST", int'(JAM_RST), 1);
        peek(1, 2, 0, "early_Cost");
        drive(1, 5, 0, 0);
        chk("early_Total", int'(Total), 66);
        do_reset();
        chk("early_rst_Load_Err", int'(Load_Err), 0);
        for (int k = 0; k < 64; k++) drive(1, $urandom_range(0, 127), k == 63, 0);
        drive(0, 0, 0, 0);
        chk("reload_Table_Ready", int'(Table_Ready), 1);

        // Beat 63 without in_last; extra beats rejected.
        do_reset();
        for (int k = 0; k < 64; k++) drive(1, k, 0, 0);
        chk("nolast_Load_Err", int'(Load_Err), 1);
        for (int k = 0; k < 3; k++) drive(1, 50, k == 2, 0);
        chk("nolast_Total", int'(Total), 2016);
        chk("nolast_JAM_RST", int'(JAM_RST), 1);

        // RST on beat 40 with in_valid high, then full reload of 100s.
        do_reset();
        for (int k = 0; k < 40; k++) drive(1, 7, 0, 0);
        drive(1, 9, 0, 1);
        chk("midrst_Total", int'(Total), 0);
        chk("midrst_in_ready", int'(in_ready), 1);
        RST = 1'b0;
        for (int k = 0; k < 64; k++) drive(1, 100, k == 63, 0);
        drive(0, 0, 0, 0);
        chk("all100_Total", int'(Total), 6400);
        for (int w = 0; w < 8; w++)
            for (int j = 0; j < 8; j++)
                peek(w, j, 100, "all100_cost");

        drive(0, 0, 0, 0);
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
